uart_tx_drain: RTL

- UART transmitter that sits directly downstream of the 256-byte transmit FIFO in the cRISCV_CPU peripheral path.
- Pops one byte at a time over the FIFO's read-request/empty interface and serialises it as 8-bit LSB-first async frames on TXD.
- Produces the physical serial line for the board's UART output.

---
 rtl/uart_tx_drain.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_drain
//
// UART transmitter fed directly by the 256-byte transmit FIFO. It reads one byte
// at a time through the FIFO's read-request/empty handshake and sends each byte
// as an asynchronous frame: a start bit, eight data bits LSB first, and one or
// two stop bits.
//
// Parameters
//   CLKS_PER_BIT : CLK cycles per bit period (2..65535), default 50 MHz/115200
//   STOP_BITS    : number of stop bits, 1 or 2
//
// Ports
//   CLK   in   system clock, rising edge
//   RSTN  in   asynchronous active-low reset
//   EN    in   transmit enable; a new frame can start only while high
//   FE    in   FIFO empty flag (combinational in the FIFO)
//   DO    in   FIFO read data, valid the cycle after RREQ is sampled high
//   RREQ  out  FIFO read request, registered single-cycle pulse
//   TXD   out  serial line, idles high
//   BUSY  out  high whenever the transmitter is not idle
//
// Frame timing, counted from the edge that leaves IDLE:
//   +1 RREQ falls (FIFO has latched its data), +2 start bit falls,
//   then (9 + STOP_BITS) * CLKS_PER_BIT cycles until the line is free again.
// -----------------------------------------------------------------------------
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       EN,
    input  logic       FE,
    input  logic [7:0] DO,
    output logic       RREQ,
    output logic       TXD,
    output logic       BUSY
);

    localparam int                 CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    // Index of the final stop bit: 0 for one stop bit, 1 for two.
    localparam logic               STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPT,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             stop_idx;
    logic             baud_done;

    // Terminal count of the baud counter marks the last cycle of a bit period.
    assign baud_done = (baud_cnt == CNT_LAST);

    // NOTE: every register here, the shift register included, is a plain flop
    // with a defined reset value; there is no storage array that would need
    // to be left unreset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= IDLE;
            TXD      <= 1'b1;
            RREQ     <= 1'b0;
            BUSY     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            stop_idx <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // branch reads the values from before this edge, the way the flops
            // actually behave.
            // RREQ defaults low so it can only ever be a one-cycle pulse.
            RREQ <= 1'b0;

            case (state)
                IDLE: begin
                    // Never request on an empty FIFO: it would return stale
                    // data. EN is only consulted here, so dropping it mid-frame
                    // lets the current frame finish untouched.
                    if (EN && !FE) begin
                        state <= REQ;
                        RREQ  <= 1'b1;
                        BUSY  <= 1'b1;
                    end
                end

                REQ: begin
                    // The FIFO samples RREQ=1 at the end of this cycle.
                    state <= CAPT;
                end

                CAPT: begin
                    shift    <= DO;
                    TXD      <= 1'b0;
                    baud_cnt <= '0;
                    state    <= START;
                end

                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        TXD      <= shift[0];
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            TXD      <= 1'b1;
                            stop_idx <= 1'b0;
                            state    <= STOP;
                        end else begin
                            // shift[1] is the bit that moves into position 0.
                            TXD <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (stop_idx == STOP_LAST) begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    TXD   <= 1'b1;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
